rr_enc_arbiter: RTL and testbench

- Round-robin arbiter that shares one downstream resource among N requesters, e.g. the priority-encoded output path.
- Issues a registered one-hot grant plus encoded index, and holds it until the owner signals done or drops its request.
- Forces release after MAX_HOLD cycles so no requester can starve the others.
- Sits between requester agents and the shared resource's select/enable inputs.

---
 rtl/rr_enc_arbiter.sv | 99 +++++++++
 tb/tb_rr_enc_arbiter.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_enc_arbiter.sv
// Round-robin arbiter with a registered one-hot grant, an encoded index and a hold-time limit.
// The grant is held until the owner signals done or drops its request, or until the limit forces a release.
module rr_enc_arbiter #(
  parameter int N        = 4,
  parameter int IDW      = $clog2(N),
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req,
  input  logic           done,
  output logic [N-1:0]   gnt,
  output logic [IDW-1:0] gnt_id,
  output logic           gnt_valid,
  output logic           timeout
);

  localparam int HCW = (MAX_HOLD > 2) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HCW-1:0] HOLD_LAST = (MAX_HOLD > 0) ? HCW'(MAX_HOLD - 1) : '0;
  localparam int SW = IDW + 1;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]     state;
  logic [IDW-1:0] ptr;
  logic [HCW-1:0] hold_cnt;

  logic [2*N-2:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [IDW-1:0] win_off;
  logic [SW-1:0]  win_sum;
  logic [IDW-1:0] win_id;
  logic [IDW-1:0] win_next_ptr;
  logic           win_found;
  logic           rel_drop;
  logic           rel_limit;
  logic           release_now;

  // Rotate the request vector so bit 0 is the requester at ptr; ptr is owner+1 while granted.
  assign req_dbl = {req[N-2:0], req};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      assign req_rot[gi] = req_dbl[{1'b0, ptr} + SW'(gi)];
    end
  endgenerate

  always_comb begin
    win_found = |req;
    win_off   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) win_off = IDW'(k);
    end
    win_sum = {1'b0, ptr} + {1'b0, win_off};
    if (win_sum >= SW'(N)) win_sum = win_sum - SW'(N);
    win_id       = win_sum[IDW-1:0];
    win_next_ptr = (win_id == IDW'(N - 1)) ? '0 : win_id + 1'b1;
  end

  assign rel_drop    = !req[gnt_id];
  assign rel_limit   = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
  assign release_now = done || rel_drop || rel_limit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_id    <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      if (state == IDLE || release_now) begin
        // timeout flags only a release the limit alone forced
        if (state == GRANT) timeout <= rel_limit && !done && !rel_drop;
        if (win_found) begin
          gnt       <= N'(1) << win_id;
          gnt_id    <= win_id;
          gnt_valid <= 1'b1;
          hold_cnt  <= '0;
          ptr       <= win_next_ptr;
          state     <= GRANT;
        end else begin
          gnt       <= '0;
          gnt_id    <= '0;
          gnt_valid <= 1'b0;
          hold_cnt  <= '0;
          state     <= IDLE;
        end
      end else begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rr_enc_arbiter.sv
// Directed and randomized checks of rr_enc_arbiter against a per-edge behavioural model
// (owner index, rotation pointer, hold count) derived from the arbitration rules.
module tb_rr_enc_arbiter;
  localparam int N        = 4;
  localparam int IDW      = $clog2(N);
  localparam int MAX_HOLD = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic           done = 1'b0;
  logic [N-1:0]   gnt;
  logic [IDW-1:0] gnt_id;
  logic           gnt_valid;
  logic           timeout;

  rr_enc_arbiter #(.N(N), .IDW(IDW), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .gnt_valid(gnt_valid), .timeout(timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_step   = 0;

  // model: owner -1 means idle
  int m_owner = -1;
  int m_ptr   = 0;
  int m_hold  = 0;
  int m_to    = 0;
  int waits[N];
  int cov_switch = 0;
  int cov_timeout = 0;
  int cov_wrap = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int find_winner(input logic [N-1:0] r, input int base);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (base + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic issue_grant(input int w);
    for (int i = 0; i < N; i++) begin
      if (i == w) waits[i] = 0;
      else if (req[i]) waits[i]++;
    end
    if (m_owner >= 0 && w != m_owner) cov_switch++;
    if (m_owner == N - 1 && w == 0) cov_wrap++;
    m_owner = w;
    m_ptr   = (w + 1) % N;
    m_hold  = 0;
  endtask

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    int w;
    bit drop, rel;
    if (!rst) begin
      m_owner = -1; m_ptr = 0; m_hold = 0; m_to = 0;
      for (int i = 0; i < N; i++) waits[i] = 0;
      return;
    end
    m_to = 0;
    if (m_owner < 0) begin
      w = find_winner(req, m_ptr);
      if (w >= 0) issue_grant(w);
    end else begin
      drop = !req[m_owner];
      rel  = done || drop || (MAX_HOLD != 0 && m_hold == MAX_HOLD - 1);
      if (rel) begin
        m_to = (!done && !drop) ? 1 : 0;
        if (m_to != 0) cov_timeout++;
        w = find_winner(req, (m_owner + 1) % N);
        if (w >= 0) issue_grant(w);
        else m_owner = -1;
      end else begin
        m_hold++;
      end
    end
    for (int i = 0; i < N; i++) if (!req[i]) waits[i] = 0;
  endtask

  task automatic step();
    logic [N-1:0] exp_gnt;
    int max_wait;
    model_edge();
    @(posedge clk);
    #1;
    exp_gnt = (m_owner < 0) ? '0 : (N'(1) << m_owner);
    check("gnt", 32'(gnt), 32'(exp_gnt));
    check("gnt_id", 32'(gnt_id), (m_owner < 0) ? 32'd0 : 32'(m_owner));
    check("gnt_valid", 32'(gnt_valid), (m_owner < 0) ? 32'd0 : 32'd1);
    check("timeout", 32'(timeout), 32'(m_to));
    check("onehot0", 32'($onehot0(gnt)), 32'd1);
    check("id_consistent", 32'(gnt), gnt_valid ? (32'd1 << gnt_id) : 32'd0);
    max_wait = 0;
    for (int i = 0; i < N; i++) if (waits[i] > max_wait) max_wait = waits[i];
    check("fairness", 32'(max_wait <= N - 1), 32'd1);
    n_step++;
    $display("step %0d rst=%b req=%b done=%b -> gnt=%b id=%0d v=%b to=%b",
             n_step, rst, req, done, gnt, gnt_id, gnt_valid, timeout);
  endtask

  initial begin
    // Reset with all requesters active
    rst = 1'b0; req = 4'b1111; done = 1'b0;
    step(); step();
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_id", 32'(gnt_id), 32'd0);
    check("rst_valid", 32'(gnt_valid), 32'd0);
    check("rst_timeout", 32'(timeout), 32'd0);
    rst = 1'b1;
    step();
    check("post_rst_gnt", 32'(gnt), 32'h1);

    // Rotation
    rst = 1'b0; step();
    rst = 1'b1; req = 4'b1010; step();
    check("rot1_gnt", 32'(gnt), 32'h2);
    check("rot1_id", 32'(gnt_id), 32'd1);
    done = 1'b1; step(); done = 1'b0;
    check("rot2_gnt", 32'(gnt), 32'h8);
    check("rot2_id", 32'(gnt_id), 32'd3);
    done = 1'b1; step(); done = 1'b0;
    check("rot3_gnt", 32'(gnt), 32'h2);

    // Request drop: move ownership to id 2, then drop everything
    req = 4'b0100; step();
    check("drop_owner2", 32'(gnt_id), 32'd2);
    req = 4'b0000; step();
    check("drop_gnt", 32'(gnt), 32'd0);
    check("drop_valid", 32'(gnt_valid), 32'd0);
    check("drop_timeout", 32'(timeout), 32'd0);

    // Timeout between two requesters
    rst = 1'b0; step();
    rst = 1'b1; req = 4'b0011; step();
    check("to_first", 32'(gnt), 32'h1);
    for (int k = 1; k < MAX_HOLD; k++) step();
    check("to_held_id0", 32'(gnt_id), 32'd0);
    step();
    check("to_switch_gnt", 32'(gnt), 32'h2);
    check("to_switch_pulse", 32'(timeout), 32'd1);
    for (int k = 1; k < MAX_HOLD; k++) step();
    check("to_held_id1", 32'(gnt_id), 32'd1);
    check("to_pulse_once", 32'(timeout), 32'd0);
    step();
    check("to_back_id0", 32'(gnt_id), 32'd0);
    check("to_back_pulse", 32'(timeout), 32'd1);

    // done on the same edge as the hold limit
    for (int k = 1; k < MAX_HOLD; k++) step();
    done = 1'b1; step(); done = 1'b0;
    check("sim_switch", 32'(gnt_id), 32'd1);
    check("sim_no_timeout", 32'(timeout), 32'd0);

    // Reset mid-grant, then pointer must restart at 0
    req = 4'b1111;
    rst = 1'b0; step();
    check("midrst_gnt", 32'(gnt), 32'd0);
    rst = 1'b1; step();
    check("midrst_ptr0", 32'(gnt_id), 32'd0);

    // Single requester re-granted on timeout
    req = 4'b0100; step();
    check("single_id2", 32'(gnt_id), 32'd2);
    for (int k = 1; k < MAX_HOLD; k++) step();
    step();
    check("single_regrant", 32'(gnt_id), 32'd2);
    check("single_timeout", 32'(timeout), 32'd1);

    // Randomized traffic
    for (int c = 0; c < 1000; c++) begin
      for (int i = 0; i < N; i++) if ($urandom_range(4, 0) == 0) req[i] = ~req[i];
      done = ($urandom_range(5, 0) == 0);
      rst  = ($urandom_range(63, 0) != 0);
      step();
    end
    rst = 1'b1; done = 1'b0;

    check("cov_switch", 32'(cov_switch > 0), 32'd1);
    check("cov_timeout", 32'(cov_timeout > 0), 32'd1);
    check("cov_wrap", 32'(cov_wrap > 0), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
